// File: rtl/reg_file.sv
// 32 x 64-bit integer register file with two combinational read ports and one write port; index 31 is XZR.
// Define REGFILE_BYPASS_EN to forward a same-cycle write onto matching read ports.
module reg_file #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NREG  = DEPTH - 1;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic              wr_valid;

    // The zero register has no storage, so a write aimed at it never matches an entry.
    assign wr_valid = RegWrite && (WriteReg != ZERO_IDX);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            always_comb begin
                regs_d[gi] = regs_q[gi];
                if (wr_valid && (WriteReg == ADDR_W'(gi))) begin
                    regs_d[gi] = WriteData;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];

    assign rd_addr[0] = ReadReg1;
    assign rd_addr[1] = ReadReg2;
    assign ReadData1  = rd_data[0];
    assign ReadData2  = rd_data[1];

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rd_data[gi] = '0;
                for (int i = 0; i < NREG; i++) begin
                    if (rd_addr[gi] == ADDR_W'(i)) begin
                        rd_data[gi] = regs_q[i];
                    end
                end
`ifdef REGFILE_BYPASS_EN
                if (wr_valid && (WriteReg == rd_addr[gi])) begin
                    rd_data[gi] = WriteData;
                end
`endif
                // Reset dominates everything, including the bypass path.
                if (rst) begin
                    rd_data[gi] = '0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected read values are queued when inputs are driven
// and compared against the combinational outputs on the following falling edge.
module tb_reg_file;
    logic        clk;
    logic        rst;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [63:0] ReadData1;
    logic [63:0] ReadData2;

    reg_file #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2),
        .WriteReg(WriteReg),
        .WriteData(WriteData),
        .RegWrite(RegWrite),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    // First falling edge at t=5 and first rising edge at t=10, so inputs driven at t=0 are checked before any edge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] e1;
        logic [63:0] e2;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mdl [32];
    int          vectors;
    int          miscompares;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [4:0] r);
        if (rst) return 64'd0;
        if (r == 5'd31) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && WriteReg != 5'd31 && WriteReg == r) return WriteData;
`endif
        return mdl[r];
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val({e.tag, ".rd1"}, ReadData1, e.e1);
            check_val({e.tag, ".rd2"}, ReadData2, e.e2);
        end
    end

    // One cycle: drive inputs, queue expected reads, take the edge, then update the reference model.
    task automatic step(input logic s_rst, input logic s_we, input logic [4:0] s_wa,
                        input logic [63:0] s_wd, input logic [4:0] s_r1, input logic [4:0] s_r2,
                        input string tag);
        exp_t e;
        rst       = s_rst;
        RegWrite  = s_we;
        WriteReg  = s_wa;
        WriteData = s_wd;
        ReadReg1  = s_r1;
        ReadReg2  = s_r2;
        e.tag = tag;
        e.e1  = exp_rd(s_r1);
        e.e2  = exp_rd(s_r2);
        sb_q.push_back(e);
        @(posedge clk);
        if (s_rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 64'd0;
        end else if (s_we && s_wa != 5'd31) begin
            mdl[s_wa] = s_wd;
        end
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 64'd0;

        step(1, 0, 0, 0, 0, 5, "rst_hold_a");
        step(1, 0, 0, 0, 5, 17, "rst_hold_b");
        step(0, 1, 5, 64'hDEAD_BEEF_0000_0001, 5, 0, "wr_x5");
        step(0, 0, 0, 0, 5, 5, "rd_x5");
        step(1, 0, 0, 0, 5, 30, "rst_pulse");
        step(0, 0, 0, 0, 5, 5, "rd_x5_after_rst");
        step(0, 1, 3, 64'h0123_4567_89AB_CDEF, 0, 0, "wr_x3");
        step(0, 0, 0, 0, 3, 3, "rd_x3_both");
        step(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, "wr_xzr");
        step(0, 0, 0, 0, 3, 31, "rd_xzr");
        step(0, 0, 7, 64'h55, 7, 7, "we_low");
        step(0, 0, 0, 0, 7, 3, "rd_x7");
        step(1, 1, 9, 64'hAA, 9, 9, "rst_vs_wr");
        step(0, 0, 0, 0, 9, 3, "rd_x9");
        step(0, 1, 12, 64'h42, 12, 12, "bypass");
        step(0, 0, 0, 0, 12, 12, "rd_x12");
        step(0, 1, 20, 64'h1, 20, 0, "b2b_a");
        step(0, 1, 20, 64'h2, 20, 0, "b2b_b");
        step(0, 0, 0, 0, 20, 20, "rd_x20");

        // Distinct value per register, then read every index pair to expose decode faults.
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 5'(i), {32'hA5A5_0000 | 32'(i), 32'(i) * 32'h0101_0101}, 5'(i), 5'(31 - i), "fill");
        end
        for (int i = 0; i < 32; i++) begin
            step(0, 0, 0, 0, 5'(i), 5'(31 - i), "sweep");
        end

        for (int n = 0; n < 60; n++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                 {$urandom, $urandom}, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        end

        check_val("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
